clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
// Parametrised successor to the CPU clock divider: free-running divide counter plus a
// glitch-free, mode-selectable CPU clock (fast tap, programmable slow tap, single-step,
// halt). Sits between the board oscillator and the CPU/debug logic. Clk_CPU is registered.
// Tap/mode changes are deferred to a safe low phase, so Clk_CPU never produces a runt high pulse.
// PARAMETERS
// CNT_W     32  width of divide counter clkdiv
// SEL_W      5  width of slow-tap select input
// FAST_TAP   2  counter bit used in RUN_FAST mode (must be < CNT_W)
// STEP_HI    4  Clk_CPU high time, in clk cycles, for one single-step pulse (>=1)
// PORTS
// clk       in   1      board clock; all logic on posedge
// rst       in   1      asynchronous, active-high reset
// mode      in   2      00 RUN_FAST, 01 RUN_SLOW, 10 STEP, 11 HALT
// sel       in   SEL_W  slow-tap bit index for RUN_SLOW; values >= CNT_W clamp to CNT_W-1
// step_btn  in   1      asynchronous step request; rising edge = one CPU pulse in STEP mode
// clkdiv    out  CNT_W  free-running counter
// Clk_CPU   out  1      CPU clock, registered
// cpu_tick  out  1      one-clk pulse, high in the clk cycle after Clk_CPU goes 0->1
// busy      out  1      high while state is SWITCH or STEP_HI
// BEHAVIOUR
// - Reset: clkdiv=0, Clk_CPU=0, cpu_tick=0, step sync flops=0, state=HALT, tap_q=FAST_TAP.
// - clkdiv += 1 every clk; wraps 2^CNT_W-1 -> 0 with no other effect.
// - Target tap: RUN_FAST -> FAST_TAP; RUN_SLOW -> min(sel, CNT_W-1).
// - step_btn: 2-flop sync (s1,s2) plus s3; rise = s2 & ~s3. Input high at edge n
//   gives rise at edge n+2.
// - States: RUN, SWITCH, HALT, STEP_IDLE, STEP_HI. cur_mode holds the mode being served.
// - RUN: Clk_CPU <= clkdiv[tap_q]. If mode != cur_mode, or RUN_SLOW and target tap != tap_q,
//   go to SWITCH.
// - SWITCH: Clk_CPU <= Clk_CPU & clkdiv[tap_q]. The current high phase completes and no new
//   rise occurs. Exit when Clk_CPU==0, using the mode sampled in that cycle:
//   * RUN_FAST/RUN_SLOW: exit only when clkdiv[target]==0; then tap_q <= target, cur_mode <= mode, go to RUN.
//   * HALT: go to HALT.  * STEP: go to STEP_IDLE.
// - HALT: Clk_CPU=0. Any mode != HALT -> SWITCH.
// - STEP_IDLE: Clk_CPU=0. On rise, go to STEP_HI with Clk_CPU<=1 and load the down-counter with STEP_HI-1.
//   Mode != STEP -> SWITCH.
// - STEP_HI: Clk_CPU=1 for exactly STEP_HI clk cycles, then Clk_CPU<=0 and go to STEP_IDLE.
//   Rises in STEP_HI are ignored. A mode change waits until STEP_HI ends.
// - Rises outside STEP_IDLE are discarded, not queued.
// - cpu_tick = Clk_CPU & ~Clk_CPU_d, registered one cycle later; reset 0.
// - Reset mid-pulse forces Clk_CPU low immediately (async) with no completion of the pulse.
// - Simultaneous mode change and step rise in STEP_IDLE: the mode change wins and the rise is dropped.
// TESTING
// 1 Reset, mode=00: after settling, Clk_CPU = clkdiv[2] delayed 1 clk, period 8 clk;
//   clkdiv counts 0,1,2,...
// 2 CNT_W=8, hold 300 clk: clkdiv wraps 255->0 and Clk_CPU stays periodic.
// 3 RUN_FAST -> RUN_SLOW sel=4 while Clk_CPU high: high phase ends normally, busy=1,
//   then period 32 clk with no high pulse shorter than 4 clk.
// 4 mode=STEP, step_btn pulse at edge n: Clk_CPU high edges n+2..n+5 (STEP_HI=4);
//   one cpu_tick; a second press during the high phase gives no extra pulse.
// 5 sel=31 with CNT_W=8: tap clamps to 7, period 256 clk.
// 6 Assert rst while in STEP_HI: Clk_CPU=0 and clkdiv=0 at once; state=HALT after release.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable CPU clock divider: free-running counter plus a glitch-free,
// mode-selectable registered CPU clock (fast tap, slow tap, single-step, halt).
module clk_div_prog #(
  parameter int CNT_W    = 32,
  parameter int SEL_W    = 5,
  parameter int FAST_TAP = 2,
  parameter int STEP_HI  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             step_btn,
  output logic [CNT_W-1:0] clkdiv,
  output logic             Clk_CPU,
  output logic             cpu_tick,
  output logic             busy
);

  localparam int TAP_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam int SC_W  = (STEP_HI > 1) ? $clog2(STEP_HI) : 1;

  localparam logic [1:0] M_FAST = 2'b00;
  localparam logic [1:0] M_SLOW = 2'b01;
  localparam logic [1:0] M_STEP = 2'b10;
  localparam logic [1:0] M_HALT = 2'b11;

  typedef enum logic [2:0] {
    S_RUN, S_SWITCH, S_HALT, S_STEP_IDLE, S_STEP_HI
  } state_t;

  state_t           st, st_n;
  logic [TAP_W-1:0] tap_q, tap_n, tgt;
  logic [1:0]       cur_mode, mode_n;
  logic [SC_W-1:0]  cnt, cnt_n;
  logic             clk_n, clk_cpu_d;
  logic             s1, s2, s3, rise;

  assign rise = s2 & ~s3;
  assign busy = (st == S_SWITCH) || (st == S_STEP_HI);

  // Tap the requested mode wants; out-of-range slow selects clamp to the MSB.
  always_comb begin
    tgt = TAP_W'(FAST_TAP);
    if (mode == M_SLOW) begin
      if (int'(sel) >= CNT_W) tgt = TAP_W'(CNT_W - 1);
      else                    tgt = TAP_W'(sel);
    end
  end

  // Free-running divide counter, step-button synchroniser and tick edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clkdiv    <= '0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      clk_cpu_d <= 1'b0;
      cpu_tick  <= 1'b0;
    end else begin
      clkdiv    <= clkdiv + CNT_W'(1);
      s1        <= step_btn;
      s2        <= s1;
      s3        <= s2;
      clk_cpu_d <= Clk_CPU;
      cpu_tick  <= Clk_CPU & ~clk_cpu_d;
    end
  end

  // State register; reset drops Clk_CPU immediately, even mid-pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_HALT;
      tap_q    <= TAP_W'(FAST_TAP);
      cur_mode <= M_HALT;
      cnt      <= '0;
      Clk_CPU  <= 1'b0;
    end else begin
      st       <= st_n;
      tap_q    <= tap_n;
      cur_mode <= mode_n;
      cnt      <= cnt_n;
      Clk_CPU  <= clk_n;
    end
  end

  // Next-state and next Clk_CPU. SWITCH only lets the running high phase
  // finish and re-enters RUN on a low target bit, so no runt pulse escapes.
  always_comb begin
    st_n   = st;
    tap_n  = tap_q;
    mode_n = cur_mode;
    cnt_n  = cnt;
    clk_n  = Clk_CPU;
    case (st)
      S_RUN: begin
        clk_n = clkdiv[tap_q];
        if (mode != cur_mode || (mode == M_SLOW && tgt != tap_q)) st_n = S_SWITCH;
      end
      S_SWITCH: begin
        clk_n = Clk_CPU & clkdiv[tap_q];
        if (!Clk_CPU) begin
          case (mode)
            M_FAST, M_SLOW: begin
              if (!clkdiv[tgt]) begin
                tap_n  = tgt;
                mode_n = mode;
                st_n   = S_RUN;
              end
            end
            M_HALT: begin
              mode_n = mode;
              st_n   = S_HALT;
            end
            default: begin
              mode_n = mode;
              st_n   = S_STEP_IDLE;
            end
          endcase
        end
      end
      S_HALT: begin
        clk_n = 1'b0;
        if (mode != M_HALT) st_n = S_SWITCH;
      end
      S_STEP_IDLE: begin
        clk_n = 1'b0;
        // A mode change takes priority over a coincident step request.
        if (mode != M_STEP) st_n = S_SWITCH;
        else if (rise) begin
          st_n  = S_STEP_HI;
          clk_n = 1'b1;
          cnt_n = SC_W'(STEP_HI - 1);
        end
      end
      S_STEP_HI: begin
        clk_n = 1'b1;
        if (cnt == '0) begin
          clk_n = 1'b0;
          st_n  = S_STEP_IDLE;
        end else begin
          cnt_n = cnt - SC_W'(1);
        end
      end
      default: begin
        clk_n = 1'b0;
        st_n  = S_HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: behavioural counter/clock model, table of mode
// vectors, randomized mode changes and hand-written step/reset sequences.
module tb_clk_div_prog;
  localparam int CNT_W = 8, SEL_W = 5, FAST_TAP = 2, STEP_HI = 4;

  logic clk = 1'b0, rst = 1'b1, step_btn = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [SEL_W-1:0] sel = '0;
  logic [CNT_W-1:0] clkdiv;
  logic Clk_CPU, cpu_tick, busy;

  clk_div_prog #(.CNT_W(CNT_W), .SEL_W(SEL_W), .FAST_TAP(FAST_TAP), .STEP_HI(STEP_HI)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .step_btn(step_btn),
    .clkdiv(clkdiv), .Clk_CPU(Clk_CPU), .cpu_tick(cpu_tick), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference counter: cycles since reset, modulo 2^CNT_W.
  int exp_div;
  always @(posedge clk or posedge rst)
    if (rst) exp_div <= 0;
    else     exp_div <= (exp_div + 1) % 256;

  // Continuous monitors: counter value, tick rule, no high pulse of unexpected length.
  logic mon_en = 1'b0;
  logic c1 = 1'b0, c2 = 1'b0;
  int hi_len = 0, old_len = 4, new_len = 4;
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      c1 <= 1'b0; c2 <= 1'b0; hi_len <= 0;
    end else begin
      chk("clkdiv", 32'(clkdiv), exp_div);
      chk("cpu_tick", 32'(cpu_tick), 32'(c1 & ~c2));
      if (!Clk_CPU && hi_len != 0)
        chk("hi_pulse_len_ok", 32'(hi_len == old_len || hi_len == new_len), 1);
      c1 <= Clk_CPU;
      c2 <= c1;
      hi_len <= Clk_CPU ? hi_len + 1 : 0;
    end
  end

  function automatic int tap_of(input logic [1:0] m, input int s);
    if (m == 2'b01) return (s > CNT_W - 1) ? CNT_W - 1 : s;
    return FAST_TAP;
  endfunction

  task automatic set_mode(input logic [1:0] m, input int s);
    @(negedge clk);
    mode = m;
    sel = SEL_W'(s);
    old_len = new_len;
    if (m == 2'b10)      new_len = STEP_HI;
    else if (m != 2'b11) new_len = 1 << tap_of(m, s);
  endtask

  task automatic settle();
    int n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < 800) begin @(negedge clk); n++; end
    chk("settle_in_time", 32'(n < 800), 1);
  endtask

  task automatic steady(input int tap, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("clk_cpu_phase", 32'(Clk_CPU), (((exp_div + 255) % 256) >> tap) & 1);
      chk("busy_run", 32'(busy), 0);
    end
  endtask

  task automatic measure(input int exp_p, input string nm);
    int w = 0, p = 0;
    bit seen_lo = 0;
    while (Clk_CPU && w < 600)  begin @(negedge clk); w++; end
    while (!Clk_CPU && w < 600) begin @(negedge clk); w++; end
    while (p < 600) begin
      @(negedge clk); p++;
      if (!Clk_CPU) seen_lo = 1;
      else if (seen_lo) break;
    end
    chk(nm, p, exp_p);
  endtask

  typedef struct {
    logic [1:0] m;
    int s;
    int tap;
    int period;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit btn_pat[16];
    bit exp_hi[16];
    int ticks, w, r_m, r_s, r_wait;
    logic [1:0] rm;

    tbl[0] = '{2'b01, 4, 4, 32};
    tbl[1] = '{2'b01, 0, 0, 2};
    tbl[2] = '{2'b01, 7, 7, 256};
    tbl[3] = '{2'b01, 31, 7, 256};
    tbl[4] = '{2'b01, 9, 7, 256};
    tbl[5] = '{2'b01, 3, 3, 16};
    tbl[6] = '{2'b00, 5, 2, 8};
    tbl[7] = '{2'b01, 2, 2, 8};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_clkdiv", 32'(clkdiv), 0);
    chk("rst_clk_cpu", 32'(Clk_CPU), 0);
    chk("rst_tick", 32'(cpu_tick), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("halt_exit_busy", 32'(busy), 1);

    // RUN_FAST after reset: period 8, counter wraps during the long runs below.
    settle();
    steady(FAST_TAP, 40);
    measure(8, "period_fast");

    // Switch to slow while Clk_CPU is high: the high phase must complete.
    w = 0;
    while (Clk_CPU && w < 50)  begin @(negedge clk); w++; end
    while (!Clk_CPU && w < 50) begin @(negedge clk); w++; end
    mode = 2'b01; sel = 5'd4; old_len = 4; new_len = 16;
    @(negedge clk);
    chk("switch_busy", 32'(busy), 1);
    chk("switch_hi_kept", 32'(Clk_CPU), 1);
    settle();
    steady(4, 40);
    measure(32, "period_slow4");

    // Table of tap/period vectors.
    for (int i = 0; i < 8; i++) begin
      set_mode(tbl[i].m, tbl[i].s);
      settle();
      steady(tbl[i].tap, 24);
      measure(tbl[i].period, "period_tbl");
    end

    // Randomized mode/tap changes at random times.
    for (int r = 0; r < 12; r++) begin
      r_m = $urandom_range(0, 3);
      r_s = $urandom_range(0, 31);
      r_wait = $urandom_range(0, 40);
      rm = (r_m == 0) ? 2'b00 : (r_m == 3) ? 2'b11 : 2'b01;
      repeat (r_wait) @(negedge clk);
      set_mode(rm, r_s);
      settle();
      if (rm == 2'b11) begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          chk("halt_low", 32'(Clk_CPU), 0);
          chk("halt_busy", 32'(busy), 0);
        end
      end else begin
        steady(tap_of(rm, r_s), 24);
        measure(2 << tap_of(rm, r_s), "period_rand");
      end
    end

    // Single step: press at edge n, high after edges n+2..n+5; re-press ignored.
    set_mode(2'b10, 0);
    settle();
    chk("step_idle_low", 32'(Clk_CPU), 0);
    for (int i = 0; i < 16; i++) begin
      btn_pat[i] = (i != 2) && (i < 13);
      exp_hi[i]  = (i >= 2) && (i <= 5);
    end
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      step_btn = btn_pat[i];
      @(negedge clk);
      chk("step_clk_cpu", 32'(Clk_CPU), 32'(exp_hi[i]));
      chk("step_busy", 32'(busy), 32'(exp_hi[i]));
      ticks += int'(cpu_tick);
    end
    chk("step_tick_count", ticks, 1);
    step_btn = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of a step pulse.
    step_btn = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_high", 32'(Clk_CPU), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_clk_cpu", 32'(Clk_CPU), 0);
    chk("rst_async_clkdiv", 32'(clkdiv), 0);
    chk("rst_async_tick", 32'(cpu_tick), 0);
    step_btn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_halt_exit", 32'(busy), 1);
    chk("post_rst_low", 32'(Clk_CPU), 0);
    settle();
    step_btn = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_step", 32'(Clk_CPU), 1);
    step_btn = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_step_end", 32'(Clk_CPU), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
